// File: rtl/bram_64k_pkg.sv
// bram_64k_pkg: bank geometry and word/address types shared by the RAM bank and its wrapper
package bram_64k_pkg;
    localparam int BANK_W = 128;
    localparam int BANK_A = 9;
    typedef logic [BANK_W-1:0] word_t;
    typedef logic [BANK_A-1:0] addr_t;
endpackage

// File: rtl/bram_64k_if.sv
// bram_64k_if: write port and always-enabled registered read port of one RAM bank
interface bram_64k_if import bram_64k_pkg::*; #(
    parameter int W = BANK_W,
    parameter int A = BANK_A
);
    logic         wr_en;
    logic [A-1:0] wr_addr;
    logic [W-1:0] wr_data;
    logic [A-1:0] rd_addr;
    logic [W-1:0] rd_data;
    modport master (output wr_en, wr_addr, wr_data, rd_addr, input rd_data);
    modport slave  (input wr_en, wr_addr, wr_data, rd_addr, output rd_data);
endinterface

// File: rtl/bram_64k.sv
// bram_64k: 512x128 simple-dual-port read-first block RAM with 1-cycle registered read
module bram_64k import bram_64k_pkg::*; #(
    parameter int W = BANK_W,
    parameter int A = BANK_A,
    parameter int C_DISABLE_WARN_BHV_COLL = 0
) (
    input  logic         clk,
    input  logic         rst,
    bram_64k_if.slave    bus
);
    logic [W-1:0] r_mem [0:2**A-1] = '{default: '0};
    logic [W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else begin
            if (bus.wr_en) r_mem[bus.wr_addr] <= bus.wr_data;
            r_rd_data <= r_mem[bus.rd_addr];
        end
    end

    assign bus.rd_data = r_rd_data;

    always @(posedge clk) begin
        if (!rst && bus.wr_en) begin
            if ($isunknown(bus.wr_addr))
                $error("bram_64k: unknown wr_addr at %0t, write skipped", $time);
            else if (C_DISABLE_WARN_BHV_COLL == 0 && bus.wr_addr == bus.rd_addr)
                $warning("bram_64k: read/write collision at %0t addr %0d", $time, bus.wr_addr);
        end
    end
endmodule

// File: tb/tb_bram_64k.sv
// tb_bram_64k: vector table, full-depth sweep and random traffic against an array reference model
module tb_bram_64k;
    import bram_64k_pkg::*;

    typedef struct {
        logic  r;
        logic  we;
        addr_t wa;
        word_t wd;
        addr_t ra;
        word_t exp;
    } vec_t;

    localparam word_t K  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam word_t VA = {32{4'hA}};
    localparam word_t VB = {32{4'hB}};
    localparam word_t FF = '1;

    logic  clk = 1'b0;
    logic  rst;
    int    checks = 0;
    int    errors = 0;
    word_t m [0:2**BANK_A-1];
    vec_t  vecs [14];

    bram_64k_if bus ();
    bram_64k #(.C_DISABLE_WARN_BHV_COLL(1)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string n, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic we, input addr_t wa, input word_t wd,
                        input addr_t ra, output word_t model);
        rst = r;
        bus.wr_en = we;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        bus.rd_addr = ra;
        @(posedge clk);
        model = r ? '0 : m[ra];
        if (!r && we) m[wa] = wd;
        #1;
    endtask

    initial begin
        word_t exp;
        for (int i = 0; i < 2**BANK_A; i++) m[i] = '0;
        vecs[0]  = '{1'b1, 1'b0, 9'd0, '0, 9'd0,   '0};
        vecs[1]  = '{1'b0, 1'b0, 9'd0, '0, 9'd100, '0};
        vecs[2]  = '{1'b0, 1'b0, 9'd0, '0, 9'd511, '0};
        vecs[3]  = '{1'b0, 1'b1, 9'd5, K,  9'd5,   '0};
        vecs[4]  = '{1'b0, 1'b0, 9'd0, '0, 9'd5,   K};
        vecs[5]  = '{1'b0, 1'b0, 9'd0, '0, 9'd5,   K};
        vecs[6]  = '{1'b0, 1'b1, 9'd7, VA, 9'd0,   '0};
        vecs[7]  = '{1'b0, 1'b1, 9'd7, VB, 9'd7,   VA};
        vecs[8]  = '{1'b0, 1'b0, 9'd0, '0, 9'd7,   VB};
        vecs[9]  = '{1'b0, 1'b1, 9'd3, FF, 9'd3,   '0};
        vecs[10] = '{1'b1, 1'b1, 9'd3, '0, 9'd3,   '0};
        vecs[11] = '{1'b1, 1'b1, 9'd3, '0, 9'd3,   '0};
        vecs[12] = '{1'b0, 1'b0, 9'd0, '0, 9'd3,   FF};
        vecs[13] = '{1'b0, 1'b0, 9'd0, '0, 9'd3,   FF};
        @(negedge clk);
        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra, exp);
            check($sformatf("vec%0d", i), bus.rd_data, vecs[i].exp);
        end
        for (int i = 0; i < 512; i++) begin
            addr_t a = addr_t'(i);
            step(1'b0, 1'b1, a, word_t'({4{a}}), 9'd0, exp);
        end
        for (int i = 0; i < 512; i++) begin
            addr_t a = addr_t'(i);
            step(1'b0, 1'b0, 9'd0, '0, a, exp);
            check($sformatf("sweep%0d", i), bus.rd_data, word_t'({4{a}}));
        end
        for (int i = 0; i < 2000; i++) begin
            logic  r  = ($urandom % 32) == 0;
            logic  we = $urandom % 2;
            addr_t wa = addr_t'(($urandom % 4 == 0) ? $urandom : $urandom % 16);
            addr_t ra = ($urandom % 3 == 0) ? wa : addr_t'($urandom % 16);
            word_t wd = {$urandom, $urandom, $urandom, $urandom};
            step(r, we, wa, wd, ra, exp);
            check($sformatf("rand%0d", i), bus.rd_data, exp);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
